// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that shares one D-latch among NUM_REQ writers with a timed setup/pulse/hold sequence.
// Define LATCH_WRITE_ARBITER_CLEAR_EN to add a clear_req_i/clear_ack_o latch clear operation.
module latch_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [NUM_REQ-1:0]        ack_o,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      busy_o,
   output logic [DATA_W-1:0]         latch_d_o,
   output logic                      latch_en_o,
   output logic                      latch_reset_n_o,
   input  logic [DATA_W-1:0]         latch_q_i
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   ,
   input  logic                      clear_req_i,
   output logic                      clear_ack_o
`endif
);

   localparam int MAX_PH = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
   localparam int CNT_W  = $clog2(MAX_PH) + 1;
   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int CAND_W = PTR_W + 1;

   // state  | meaning
   // IDLE   | arbitrate | SETUP d stable, en low | ENABLE en high | HOLD d held, en low | ACK report | CLEAR latch reset
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ENABLE = 3'd2,
      HOLD   = 3'd3,
      ACK    = 3'd4
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      ,
      CLEAR  = 3'd5
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   latch_d_q, latch_d_d;
   logic                latch_en_q, latch_en_d;
   logic [PTR_W-1:0]    win_idx;
   logic [CAND_W-1:0]   cand;

`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   logic lrn_q, lrn_d;
   logic clear_ack_q, clear_ack_d;
`endif

   // Scan from the farthest candidate back so the one nearest the pointer wins.
   always_comb begin
      win_idx = '0;
      cand    = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = {1'b0, ptr_q} + CAND_W'(off);
         if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
         if (req_i[cand[PTR_W-1:0]]) win_idx = cand[PTR_W-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      ack_d      = '0;
      rd_data_d  = rd_data_q;
      busy_d     = busy_q;
      latch_d_d  = latch_d_q;
      latch_en_d = latch_en_q;
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      lrn_d       = 1'b1;
      clear_ack_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
            if (clear_req_i) begin
               state_d = CLEAR;
               cnt_d   = CNT_W'(PULSE_CYC - 1);
               busy_d  = 1'b1;
               lrn_d   = 1'b0;
            end else
`endif
            if (|req_i) begin
               state_d          = SETUP;
               cnt_d            = CNT_W'(SETUP_CYC - 1);
               busy_d           = 1'b1;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               latch_d_d        = req_data_i[win_idx*DATA_W +: DATA_W];
               ptr_d            = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d    = ENABLE;
               cnt_d      = CNT_W'(PULSE_CYC - 1);
               latch_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ENABLE: begin
            if (cnt_q == '0) begin
               state_d    = HOLD;
               cnt_d      = CNT_W'(HOLD_CYC - 1);
               latch_en_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d   = ACK;
               rd_data_d = latch_q_i;
               ack_d     = grant_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
         CLEAR: begin
            if (cnt_q == '0) begin
               state_d     = ACK;
               clear_ack_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
               lrn_d = 1'b0;
            end
         end
`endif
         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            busy_d     = 1'b0;
            latch_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
         latch_d_q  <= '0;
         latch_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         latch_d_q  <= latch_d_d;
         latch_en_q <= latch_en_d;
      end
   end

`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   // The latch is held in reset for as long as the arbiter itself is.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lrn_q       <= 1'b0;
         clear_ack_q <= 1'b0;
      end else begin
         lrn_q       <= lrn_d;
         clear_ack_q <= clear_ack_d;
      end
   end

   assign latch_reset_n_o = lrn_q;
   assign clear_ack_o     = clear_ack_q;
`else
   assign latch_reset_n_o = 1'b1;
`endif

   assign grant_o    = grant_q;
   assign ack_o      = ack_q;
   assign rd_data_o  = rd_data_q;
   assign busy_o     = busy_q;
   assign latch_d_o  = latch_d_q;
   assign latch_en_o = latch_en_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed scenarios plus a random run against a transaction-level model.
module tb_latch_write_arbiter;

   localparam int S = 1, P = 1, H = 1;
   localparam int LAST = S + P + H;
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   localparam logic LRN_RST = 1'b0;
`else
   localparam logic LRN_RST = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant, ack;
   logic [7:0]  rd_data, l_d, l_q;
   logic        busy, l_en, l_rst_n;

   logic        rst_t;
   logic [3:0]  req_t;
   logic [31:0] req_data_t;
   logic [3:0]  grant_t, ack_t;
   logic [7:0]  rd_data_t, l_d_t, l_q_t;
   logic        busy_t, l_en_t, l_rst_n_t;

`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   logic clear_req, clear_ack, clear_req_t, clear_ack_t;
`endif

   int checks = 0;
   int errors = 0;

   latch_write_arbiter u_dut (
      .clk_i(clk), .reset_i(rst), .req_i(req), .req_data_i(req_data),
      .grant_o(grant), .ack_o(ack), .rd_data_o(rd_data), .busy_o(busy),
      .latch_d_o(l_d), .latch_en_o(l_en), .latch_reset_n_o(l_rst_n), .latch_q_i(l_q)
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      , .clear_req_i(clear_req), .clear_ack_o(clear_ack)
`endif
   );

   latch_write_arbiter #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_t (
      .clk_i(clk), .reset_i(rst_t), .req_i(req_t), .req_data_i(req_data_t),
      .grant_o(grant_t), .ack_o(ack_t), .rd_data_o(rd_data_t), .busy_o(busy_t),
      .latch_d_o(l_d_t), .latch_en_o(l_en_t), .latch_reset_n_o(l_rst_n_t), .latch_q_i(l_q_t)
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      , .clear_req_i(clear_req_t), .clear_ack_o(clear_ack_t)
`endif
   );

   // Behavioural D-latches driven by each arbiter.
   always_latch begin
      if (!l_rst_n) l_q <= '0;
      else if (l_en) l_q <= l_d;
   end

   always_latch begin
      if (!l_rst_n_t) l_q_t <= '0;
      else if (l_en_t) l_q_t <= l_d_t;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_data = '0;
      rst_t = 1'b1; req_t = '0; req_data_t = '0;
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      clear_req = 1'b0; clear_req_t = 1'b0;
`endif
      tick(); tick();
      checks++;
      if ({grant, ack, busy, l_en} !== 10'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want %b", {grant, ack, busy, l_en}, 10'b0);
      end
      checks++;
      if ({rd_data, l_d} !== 16'h0) begin
         errors++; $display("FAIL reset_data got %h want %h", {rd_data, l_d}, 16'h0);
      end
      checks++;
      if (l_rst_n !== LRN_RST) begin
         errors++; $display("FAIL reset_lrn got %b want %b", l_rst_n, LRN_RST);
      end
      rst = 1'b0; rst_t = 1'b0;
      for (int e = 1; e <= 2; e++) begin
         tick();
         checks++;
         if ({grant, busy, l_en, l_rst_n} !== 7'b0000001) begin
            errors++; $display("FAIL idle_noreq e%0d got %b want %b", e, {grant, busy, l_en, l_rst_n}, 7'b0000001);
         end
      end
   endtask

   task automatic test_single_write();
      logic [3:0] eg, ea;
      logic       ee, eb;
      req = 4'b0001; req_data = 32'h0000_00A5;
      for (int e = 1; e <= 6; e++) begin
         tick();
         eg = (e <= 4) ? 4'b0001 : 4'b0000;
         ea = (e == 4) ? 4'b0001 : 4'b0000;
         ee = (e == 2);
         eb = (e <= 4);
         checks++;
         if ({grant, ack, busy, l_en, l_rst_n} !== {eg, ea, eb, ee, 1'b1}) begin
            errors++; $display("FAIL single_ctrl e%0d got %b want %b", e, {grant, ack, busy, l_en, l_rst_n}, {eg, ea, eb, ee, 1'b1});
         end
         checks++;
         if (l_d !== 8'hA5) begin
            errors++; $display("FAIL single_latch_d e%0d got %h want a5", e, l_d);
         end
         if (e >= 4) begin
            checks++;
            if (rd_data !== 8'hA5) begin
               errors++; $display("FAIL single_rd e%0d got %h want a5", e, rd_data);
            end
         end
         if (e == 4) req = '0;
      end
   endtask

   task automatic test_contention();
      logic [7:0] dat [4];
      logic [3:0] eg, ea;
      int n, k, o;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) dat[i] = 8'((i + 1) * 17);
      req_data = {dat[3], dat[2], dat[1], dat[0]};
      req = 4'hF;
      for (int e = 1; e <= 25; e++) begin
         tick();
         n = (e - 1) / 5; k = (e - 1) % 5; o = n % 4;
         eg = (k <= 3) ? 4'(1 << o) : 4'b0;
         ea = (k == 3) ? 4'(1 << o) : 4'b0;
         checks++;
         if ({grant, ack, busy, l_en} !== {eg, ea, k <= 3, k == 1}) begin
            errors++; $display("FAIL contention_ctrl e%0d got %b want %b", e, {grant, ack, busy, l_en}, {eg, ea, k <= 3, k == 1});
         end
         checks++;
         if (l_d !== dat[o]) begin
            errors++; $display("FAIL contention_latch_d e%0d got %h want %h", e, l_d, dat[o]);
         end
         if (k == 3) begin
            checks++;
            if (rd_data !== dat[o]) begin
               errors++; $display("FAIL contention_rd e%0d got %h want %h", e, rd_data, dat[o]);
            end
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_stability();
      logic [3:0] eg, ea;
      req = 4'b0100; req_data = 32'h005C_0000;
      for (int e = 1; e <= 6; e++) begin
         tick();
         eg = (e <= 4) ? 4'b0100 : 4'b0000;
         ea = (e == 4) ? 4'b0100 : 4'b0000;
         checks++;
         if ({grant, ack, busy, l_en} !== {eg, ea, e <= 4, e == 2}) begin
            errors++; $display("FAIL stable_ctrl e%0d got %b want %b", e, {grant, ack, busy, l_en}, {eg, ea, e <= 4, e == 2});
         end
         checks++;
         if (l_d !== 8'h5C) begin
            errors++; $display("FAIL stable_latch_d e%0d got %h want 5c", e, l_d);
         end
         if (e == 4) begin
            checks++;
            if (rd_data !== 8'h5C) begin
               errors++; $display("FAIL stable_rd got %h want 5c", rd_data);
            end
         end
         if (e == 1) begin
            req_data = 32'h00C3_0000;
            req = '0;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] eg, ea, own;
      logic [7:0] od;
      int k;
      req = 4'b0001; req_data = 32'h0000_003C;
      tick(); tick();
      checks++;
      if ({grant, l_en} !== 5'b00011) begin
         errors++; $display("FAIL midrst_pre got %b want %b", {grant, l_en}, 5'b00011);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({grant, ack, busy, l_en, l_d, rd_data} !== 26'b0) begin
         errors++; $display("FAIL midrst_clear got %h want 0", {grant, ack, busy, l_en, l_d, rd_data});
      end
      rst = 1'b0;
      req = 4'b1001; req_data = 32'h7700_003C;
      for (int e = 1; e <= 10; e++) begin
         tick();
         own = (e <= 5) ? 4'b0001 : 4'b1000;
         od  = (e <= 5) ? 8'h3C : 8'h77;
         k   = (e <= 5) ? e - 1 : e - 6;
         eg  = (k <= 3) ? own : 4'b0;
         ea  = (k == 3) ? own : 4'b0;
         checks++;
         if ({grant, ack, busy, l_en} !== {eg, ea, k <= 3, k == 1}) begin
            errors++; $display("FAIL midrst_ctrl e%0d got %b want %b", e, {grant, ack, busy, l_en}, {eg, ea, k <= 3, k == 1});
         end
         if (k == 3) begin
            checks++;
            if (rd_data !== od) begin
               errors++; $display("FAIL midrst_rd e%0d got %h want %h", e, rd_data, od);
            end
         end
         if (e == 4) req = 4'b1000;
         if (e == 9) req = '0;
      end
   endtask

   task automatic test_timing();
      logic ee;
      req_t = 4'b0001; req_data_t = 32'h0000_0096;
      for (int e = 1; e <= 10; e++) begin
         tick();
         ee = (e >= 3) && (e <= 5);
         checks++;
         if ({grant_t, ack_t, busy_t, l_en_t} !== {(e <= 8) ? 4'b0001 : 4'b0, (e == 8) ? 4'b0001 : 4'b0, e <= 8, ee}) begin
            errors++; $display("FAIL timing_ctrl e%0d got %b want %b", e, {grant_t, ack_t, busy_t, l_en_t},
                               {(e <= 8) ? 4'b0001 : 4'b0, (e == 8) ? 4'b0001 : 4'b0, e <= 8, ee});
         end
         if (e == 8) begin
            checks++;
            if (rd_data_t !== 8'h96) begin
               errors++; $display("FAIL timing_rd got %h want 96", rd_data_t);
            end
            req_t = '0;
         end
      end
   endtask

`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
   task automatic test_clear();
      logic [3:0] eg, ea;
      logic       eb;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      clear_req = 1'b1; req = 4'b0010; req_data = 32'h0000_4B00;
      for (int e = 1; e <= 8; e++) begin
         tick();
         eg = (e >= 4 && e <= 7) ? 4'b0010 : 4'b0;
         ea = (e == 7) ? 4'b0010 : 4'b0;
         eb = (e <= 2) || (e >= 4 && e <= 7);
         checks++;
         if ({grant, ack, busy, l_en, l_rst_n, clear_ack} !== {eg, ea, eb, e == 5, e != 1, e == 2}) begin
            errors++; $display("FAIL clear_ctrl e%0d got %b want %b", e, {grant, ack, busy, l_en, l_rst_n, clear_ack},
                               {eg, ea, eb, e == 5, e != 1, e == 2});
         end
         checks++;
         if (l_d !== ((e >= 4) ? 8'h4B : 8'h00)) begin
            errors++; $display("FAIL clear_latch_d e%0d got %h want %h", e, l_d, (e >= 4) ? 8'h4B : 8'h00);
         end
         if (e == 2) begin
            checks++;
            if (l_q !== 8'h00) begin
               errors++; $display("FAIL clear_q got %h want 00", l_q);
            end
         end
         if (e == 1) clear_req = 1'b0;
         if (e == 7) req = '0;
      end
   endtask
`endif

   task automatic test_random();
      int mk, mwin, mptr, idx;
      logic [7:0] mld, mrd;
      logic [3:0] eg, ea;
      logic       ee, eb, elrn;
      rst = 1'b1; req = '0; req_data = '0;
      tick();
      rst = 1'b0;
      mk = -1; mwin = 0; mptr = 0; mld = '0; mrd = '0;
      eg = '0; ea = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 4; i++) begin
            if (ea[i]) req[i] = 1'b0;
            else if (!req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[i] = 1'b1;
                  req_data[i*8 +: 8] = 8'($urandom);
               end
            end else if (eg[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
            if (eg[i] && $urandom_range(0, 3) == 0) req_data[i*8 +: 8] = 8'($urandom);
         end
         tick();
         if (rst) begin
            mk = -1; mptr = 0; mld = '0; mrd = '0;
         end else if (mk < 0) begin
            if (req != 4'b0) begin
               for (int off = 0; off < 4; off++) begin
                  idx = (mptr + off) % 4;
                  if (req[idx]) begin
                     mwin = idx;
                     break;
                  end
               end
               mk = 0;
               mptr = (mwin + 1) % 4;
               mld = req_data[mwin*8 +: 8];
            end
         end else begin
            mk++;
            if (mk == LAST) mrd = mld;
            if (mk > LAST) mk = -1;
         end
         eg   = (mk >= 0) ? 4'(1 << mwin) : 4'b0;
         ea   = (mk == LAST) ? 4'(1 << mwin) : 4'b0;
         ee   = (mk >= S) && (mk < S + P);
         eb   = (mk >= 0);
         elrn = rst ? LRN_RST : 1'b1;
         checks++;
         if ({grant, ack, busy, l_en, l_rst_n} !== {eg, ea, eb, ee, elrn}) begin
            errors++; $display("FAIL rand_ctrl cyc%0d got %b want %b", cyc, {grant, ack, busy, l_en, l_rst_n}, {eg, ea, eb, ee, elrn});
         end
         checks++;
         if ({l_d, rd_data} !== {mld, mrd}) begin
            errors++; $display("FAIL rand_data cyc%0d got %h want %h", cyc, {l_d, rd_data}, {mld, mrd});
         end
      end
      rst = 1'b0; req = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_stability();
      test_reset_mid();
      test_timing();
`ifdef LATCH_WRITE_ARBITER_CLEAR_EN
      test_clear();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
- Round-robin arbiter and write sequencer that shares one D-latch register (D, enable, reset_n → Q, not_Q) among NUM_REQ requesters.
- Per write: grants one requester, registers its data onto the latch D input, then drives a timed setup / enable-pulse / hold sequence on the latch enable. After hold it samples Q for readback and acknowledges the requester.
- Sits between the requesting logic and the latch instance. It is the only driver of the latch D, enable and reset_n pins.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 8, latch data width.
- SETUP_CYC, 1, clock cycles latch_d is stable before latch_en rises (≥1).
- PULSE_CYC, 1, clock cycles latch_en is high (≥1).
- HOLD_CYC, 1, clock cycles latch_d is held after latch_en falls (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, level; held until matching ack.
- req_data  input  NUM_REQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot, current owner; high from grant cycle through ACK.
- ack  output  NUM_REQ  one-cycle pulse to the owner at write completion.
- rd_data  output  DATA_W  latch_q sampled in the final HOLD cycle; valid with ack, held until next ack.
- busy  output  1  high in every state except IDLE.
- latch_d  output  DATA_W  to latch D.
- latch_en  output  1  to latch enable.
- latch_reset_n  output  1  to latch reset_n (active-low).
- latch_q  input  DATA_W  from latch Q.

Behaviour:
- All outputs are registered.
- Reset values: grant=0, ack=0, rd_data=0, busy=0, latch_d=0, latch_en=0, latch_reset_n=1. State=IDLE, round-robin pointer=0 (requester 0 has highest priority).
- FSM states: IDLE → SETUP → ENABLE → HOLD → ACK → IDLE.
- IDLE: if any req is high, select the first requester at or after the pointer (wrapping). At the next edge, set grant to that one-hot, capture its req_data into latch_d, go to SETUP, and set pointer = winner+1 mod NUM_REQ.
- SETUP: lasts SETUP_CYC cycles; latch_en=0.
- ENABLE: lasts PULSE_CYC cycles; latch_en=1.
- HOLD: lasts HOLD_CYC cycles; latch_en=0 and latch_d unchanged. Sample latch_q into rd_data on the last HOLD edge.
- ACK: lasts 1 cycle; ack[winner]=1 and grant is still asserted. Next edge returns to IDLE with grant=0 and ack=0.
- latch_d changes only on the grant edge. It holds its value in IDLE after a write.
- Phase lengths are counted with one down-counter of width $clog2(max phase)+1.
- Latency, with req first sampled in IDLE at edge 0:
  - grant at edge 1;
  - latch_en rises at edge 1+SETUP_CYC;
  - ack at edge 1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
  - Defaults give ack at edge 4 and one write per 5 cycles.
- Boundary conditions:
  - Requests arriving during a transaction wait; they are arbitrated only in IDLE.
  - req dropping mid-transaction does not abort it; the sequence and ack still complete.
  - req_data changing after grant is ignored.
  - Simultaneous requests are resolved by the round-robin pointer. Pointer wrap goes from NUM_REQ-1 to 0.
  - reset during any state returns everything to reset values at that edge: latch_en forced low, no ack issued, pointer cleared.
  - No req in IDLE: stay in IDLE, outputs unchanged.

Optional Feature:
- Macro: LATCH_WRITE_ARBITER_CLEAR_EN.
- Defined:
  - Adds input clear_req (1) and output clear_ack (1).
  - In IDLE, clear_req beats all req and does not move the pointer.
  - FSM goes to CLEAR for PULSE_CYC cycles with latch_reset_n=0 and latch_en=0, then ACK with clear_ack=1 for one cycle, then IDLE.
  - latch_d, grant and rd_data are untouched by a clear.
  - latch_reset_n is also driven 0 while reset is high.
- Undefined: the ports are absent, latch_reset_n is constant 1, and the CLEAR state does not exist.

Test Plan:
- Single write, defaults: reset 2 cycles, then req=0001 with data 0xA5 → grant=0001 at edge 1, latch_en high only at edge 2, ack[0] and rd_data=0xA5 at edge 4, busy low from edge 5.
- Contention: req=1111 held, distinct data per requester → grants in order 0,1,2,3,0, each ack 5 cycles apart, latch_d matching each owner's data.
- Data/req stability: requester 2 changes req_data and drops req one cycle after grant → latch_d keeps the captured value, ack[2] still pulses at edge 4.
- Reset mid-op: assert reset during ENABLE → next edge latch_en=0, grant=0, busy=0, no ack. Then req=1000 after reset → requester 3 is granted (pointer cleared).
- Timing parameters SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2 → latch_en high for exactly 3 cycles starting edge 3, ack at edge 8.
- With LATCH_WRITE_ARBITER_CLEAR_EN: clear_req and req=0010 together in IDLE → latch_reset_n low 1 cycle, clear_ack at edge 2, then requester 1 granted at edge 4.
